// File: rtl/kmac_pkg.sv
// Shared definitions for the rom_ctrl -> KMAC receive path.
//   kmac_rx_state_e : receiver FSM state, sparse 10-bit encoding with a
//                     pairwise Hamming distance of at least 3.
//   KmacRxStrbFull  : byte strobes for a block carrying two ROM words.
//   KmacRxStrbHalf  : byte strobes for a block carrying one ROM word.
package kmac_pkg;

    typedef enum logic [9:0] {
        StIdle       = 10'b1100101001,
        StAbsorb     = 10'b0111010010,
        StWaitDigest = 10'b1011100100,
        StDone       = 10'b0000111111,
        StError      = 10'b1101011110
    } kmac_rx_state_e;

    localparam logic [7:0] KmacRxStrbFull = 8'hFF;
    localparam logic [7:0] KmacRxStrbHalf = 8'h0F;

endpackage

// File: rtl/rom_ctrl_kmac_packer.sv
// Packs 32-bit ROM words into 64-bit blocks and holds one block for the core.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   word_we_i          word accepted this cycle (only asserted when space_o)
//   word_data_i        accepted word
//   word_last_i        accepted word is the final word of the message
//   flush_i            drop any half-packed word and pending block
//   space_o            block register can take a new block this cycle
//   blk_vld_o/rdy_i    block handshake towards the sponge core
//   blk_data_o         block payload, first word in [31:0]
//   blk_strb_o         byte strobes (full or half block)
//   blk_last_o         final block of the message
module rom_ctrl_kmac_packer
    import kmac_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        word_we_i,
    input  logic [31:0] word_data_i,
    input  logic        word_last_i,
    input  logic        flush_i,
    output logic        space_o,
    output logic        blk_vld_o,
    input  logic        blk_rdy_i,
    output logic [63:0] blk_data_o,
    output logic [7:0]  blk_strb_o,
    output logic        blk_last_o
);

    logic        half_q;
    logic [31:0] low_q;
    logic        vld_q;
    logic [63:0] data_q;
    logic [7:0]  strb_q;
    logic        last_q;

    // A new block may only be loaded when the register is empty or being
    // drained this cycle, so the payload never changes under a stalled valid.
    assign space_o = !vld_q || blk_rdy_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            half_q <= 1'b0;
            low_q  <= '0;
            vld_q  <= 1'b0;
            data_q <= '0;
            strb_q <= '0;
            last_q <= 1'b0;
        end else if (flush_i) begin
            half_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            if (vld_q && blk_rdy_i) begin
                vld_q <= 1'b0;
            end
            if (word_we_i) begin
                if (half_q) begin
                    data_q <= {word_data_i, low_q};
                    strb_q <= KmacRxStrbFull;
                    last_q <= word_last_i;
                    vld_q  <= 1'b1;
                    half_q <= 1'b0;
                end else if (word_last_i) begin
                    data_q <= {32'h0, word_data_i};
                    strb_q <= KmacRxStrbHalf;
                    last_q <= 1'b1;
                    vld_q  <= 1'b1;
                end else begin
                    low_q  <= word_data_i;
                    half_q <= 1'b1;
                end
            end
        end
    end

    assign blk_vld_o  = vld_q;
    assign blk_data_o = data_q;
    assign blk_strb_o = strb_q;
    assign blk_last_o = last_q;

endmodule

// File: rtl/rom_ctrl_kmac_rx.sv
// KMAC-side receiver for the rom_ctrl ROM-hash stream.
// Accepts 32-bit ROM words (rom_vld_i/rom_rdy_o/rom_last_i), forwards 64-bit
// blocks to the sponge core (blk_*), and returns the core digest to rom_ctrl
// as a one-cycle kmac_done_o pulse with a held kmac_digest_o and a sticky
// kmac_err_o. The FSM is linear: Idle -> Absorb -> WaitDigest -> Done, with
// Error reachable from any state; Done and Error are terminal until reset.
module rom_ctrl_kmac_rx
    import kmac_pkg::*;
#(
    parameter  int unsigned DigestWords = 8,
    localparam int unsigned DigestW     = DigestWords * 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rom_vld_i,
    output logic               rom_rdy_o,
    input  logic [31:0]        rom_data_i,
    input  logic               rom_last_i,
    output logic               blk_vld_o,
    input  logic               blk_rdy_i,
    output logic [63:0]        blk_data_o,
    output logic [7:0]         blk_strb_o,
    output logic               blk_last_o,
    input  logic               core_done_i,
    input  logic [DigestW-1:0] core_digest_i,
    input  logic               core_err_i,
    output logic               kmac_done_o,
    output logic [DigestW-1:0] kmac_digest_o,
    output logic               kmac_err_o
);

    kmac_rx_state_e     state_q;
    logic               last_acc_q;
    logic               done_q;
    logic               done_issued_q;
    logic               err_q;
    logic [DigestW-1:0] digest_q;

    logic space;
    logic accept;
    logic err_entry;

    // Once the last word is in, further words are held off rather than
    // being packed into a block that would follow the final one.
    assign rom_rdy_o = rst_ni && space &&
                       ((state_q == StIdle) || (state_q == StAbsorb && !last_acc_q));
    assign accept    = rom_vld_i && rom_rdy_o;

    always_comb begin
        err_entry = 1'b0;
        case (state_q)
            StIdle, StAbsorb: err_entry = core_err_i || core_done_i;
            StWaitDigest:     err_entry = core_err_i || rom_vld_i;
            StDone:           err_entry = core_err_i || core_done_i || rom_vld_i;
            StError:          err_entry = 1'b0;
            default:          err_entry = 1'b1;
        endcase
    end

    rom_ctrl_kmac_packer u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .word_we_i   (accept),
        .word_data_i (rom_data_i),
        .word_last_i (rom_last_i),
        .flush_i     (err_entry),
        .space_o     (space),
        .blk_vld_o   (blk_vld_o),
        .blk_rdy_i   (blk_rdy_i),
        .blk_data_o  (blk_data_o),
        .blk_strb_o  (blk_strb_o),
        .blk_last_o  (blk_last_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            last_acc_q    <= 1'b0;
            done_q        <= 1'b0;
            done_issued_q <= 1'b0;
            err_q         <= 1'b0;
            digest_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (err_entry) begin
                // Error beats a simultaneous core_done_i: no digest capture.
                state_q <= StError;
                err_q   <= 1'b1;
                if (!done_issued_q) begin
                    done_q        <= 1'b1;
                    done_issued_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        if (accept) begin
                            state_q    <= StAbsorb;
                            last_acc_q <= rom_last_i;
                        end
                    end
                    StAbsorb: begin
                        if (accept && rom_last_i) begin
                            last_acc_q <= 1'b1;
                        end
                        if (blk_vld_o && blk_rdy_i && blk_last_o) begin
                            state_q <= StWaitDigest;
                        end
                    end
                    StWaitDigest: begin
                        if (core_done_i) begin
                            digest_q      <= core_digest_i;
                            done_q        <= 1'b1;
                            done_issued_q <= 1'b1;
                            state_q       <= StDone;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign kmac_done_o   = done_q;
    assign kmac_err_o    = err_q;
    assign kmac_digest_o = digest_q;

    // Tracks whether kmac_done_o has already been seen since reset.
    logic done_pulsed_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_pulsed_q <= 1'b0;
        end else if (done_q) begin
            done_pulsed_q <= 1'b1;
        end
    end

    a_blk_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        blk_vld_o && !blk_rdy_i |=>
        kmac_err_o || (blk_vld_o && $stable({blk_data_o, blk_strb_o, blk_last_o})));

    a_done_once: assert property (@(posedge clk_i) disable iff (!rst_ni)
        kmac_done_o |-> !done_pulsed_q);

    a_rdy_idle_absorb: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(state_q inside {StIdle, StAbsorb}) |-> !rom_rdy_o);

    a_fsm_no_idle_return: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_q != StIdle |=> state_q != StIdle);

    a_fsm_no_absorb_return: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_q inside {StWaitDigest, StDone, StError} |=> !(state_q inside {StIdle, StAbsorb}));

    a_fsm_done_terminal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_q == StDone |=> state_q inside {StDone, StError});

    a_fsm_err_terminal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        state_q == StError |=> state_q == StError);

endmodule

// File: tb/tb_rom_ctrl_kmac_rx.sv
module tb_rom_ctrl_kmac_rx;

    localparam int unsigned DigestWords = 8;
    localparam int unsigned DigestW     = DigestWords * 32;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               rom_vld_i = 1'b0;
    logic               rom_rdy_o;
    logic [31:0]        rom_data_i = '0;
    logic               rom_last_i = 1'b0;
    logic               blk_vld_o;
    logic               blk_rdy_i = 1'b0;
    logic [63:0]        blk_data_o;
    logic [7:0]         blk_strb_o;
    logic               blk_last_o;
    logic               core_done_i = 1'b0;
    logic [DigestW-1:0] core_digest_i = '0;
    logic               core_err_i = 1'b0;
    logic               kmac_done_o;
    logic [DigestW-1:0] kmac_digest_o;
    logic               kmac_err_o;

    rom_ctrl_kmac_rx #(.DigestWords(DigestWords)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rom_vld_i     (rom_vld_i),
        .rom_rdy_o     (rom_rdy_o),
        .rom_data_i    (rom_data_i),
        .rom_last_i    (rom_last_i),
        .blk_vld_o     (blk_vld_o),
        .blk_rdy_i     (blk_rdy_i),
        .blk_data_o    (blk_data_o),
        .blk_strb_o    (blk_strb_o),
        .blk_last_o    (blk_last_o),
        .core_done_i   (core_done_i),
        .core_digest_i (core_digest_i),
        .core_err_i    (core_err_i),
        .kmac_done_o   (kmac_done_o),
        .kmac_digest_o (kmac_digest_o),
        .kmac_err_o    (kmac_err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    logic [31:0] words [16];

    typedef struct {
        int         n;
        int         pct;
        int         stall;
        int         exp_blocks;
        logic [7:0] exp_last_strb;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [DigestW-1:0] act, input logic [DigestW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference block b of an n-word message, built directly from the word list.
    function automatic void exp_block(input int n, input int b, output logic [63:0] d,
                                      output logic [7:0] s, output logic l);
        if (2 * b + 1 >= n) begin
            d = {32'h0, words[2*b]};
            s = 8'h0F;
            l = 1'b1;
        end else begin
            d = {words[2*b+1], words[2*b]};
            s = 8'hFF;
            l = (2 * b + 2 == n);
        end
    endfunction

    function automatic logic [DigestW-1:0] rand_digest();
        logic [DigestW-1:0] d;
        for (int i = 0; i < int'(DigestWords); i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic do_reset();
        rst_ni = 1'b0;
        rom_vld_i = 1'b0; rom_data_i = '0; rom_last_i = 1'b0; blk_rdy_i = 1'b0;
        core_done_i = 1'b0; core_err_i = 1'b0; core_digest_i = '0;
        @(posedge clk_i); #1;
        chk("rst_rom_rdy", rom_rdy_o, 0);
        chk("rst_blk_vld", blk_vld_o, 0);
        chk("rst_done", kmac_done_o, 0);
        chk("rst_err", kmac_err_o, 0);
        chk("rst_digest", kmac_digest_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    // Sends words[0..n-1] and checks every block against the reference list.
    // Model: one block may be pending; it appears the cycle after the word
    // that completes it (odd index or final word) and leaves when taken.
    task automatic run_msg(input int n, input int pct, input int stall,
                           output int nblk_obs, output logic [7:0] last_strb_obs);
        int acc = 0;
        int bi = 0;
        int cyc = 0;
        int nb = (n + 1) / 2;
        bit pend = 0;
        bit take, accm;
        logic [63:0] ed;
        logic [7:0]  es;
        logic        el;
        nblk_obs = 0;
        last_strb_obs = '0;
        while (bi < nb && cyc < 400) begin
            rom_vld_i  = (acc < n);
            rom_data_i = (acc < n) ? words[acc] : 32'h0;
            rom_last_i = (acc == n - 1);
            blk_rdy_i  = (cyc < stall) ? 1'b0 : ($urandom_range(99) < pct);
            #1;
            chk("blk_vld", blk_vld_o, pend);
            if (pend) begin
                exp_block(n, bi, ed, es, el);
                chk("blk_data", blk_data_o, ed);
                chk("blk_strb", blk_strb_o, es);
                chk("blk_last", blk_last_o, el);
            end
            if (rom_vld_i) chk("rom_rdy", rom_rdy_o, !pend || blk_rdy_i);
            if (blk_vld_o && blk_rdy_i) begin
                nblk_obs++;
                if (blk_last_o) last_strb_obs = blk_strb_o;
            end
            take = pend && blk_rdy_i;
            accm = rom_vld_i && (!pend || blk_rdy_i);
            @(posedge clk_i); #1;
            if (take) begin
                bi++;
                pend = 0;
            end
            if (accm) begin
                if (acc % 2 == 1 || acc == n - 1) pend = 1;
                acc++;
            end
            cyc++;
        end
        chk("msg_blocks_taken", bi, nb);
        rom_vld_i = 1'b0; rom_last_i = 1'b0; rom_data_i = '0; blk_rdy_i = 1'b0;
    endtask

    task automatic finish_digest(input logic [DigestW-1:0] d);
        chk("wait_rom_rdy", rom_rdy_o, 0);
        core_done_i = 1'b1; core_digest_i = d;
        @(posedge clk_i); #1;
        core_done_i = 1'b0; core_digest_i = '0;
        chk("done_pulse", kmac_done_o, 1);
        chk("digest", kmac_digest_o, d);
        chk("err_clear", kmac_err_o, 0);
        @(posedge clk_i); #1;
        chk("done_single", kmac_done_o, 0);
        chk("digest_held", kmac_digest_o, d);
    endtask

    initial begin
        int nobs;
        logic [7:0] lstrb;
        logic [DigestW-1:0] dg;

        vecs[0] = '{n: 4,  pct: 100, stall: 0, exp_blocks: 2, exp_last_strb: 8'hFF};
        vecs[1] = '{n: 3,  pct: 100, stall: 0, exp_blocks: 2, exp_last_strb: 8'h0F};
        vecs[2] = '{n: 4,  pct: 100, stall: 7, exp_blocks: 2, exp_last_strb: 8'hFF};
        vecs[3] = '{n: 1,  pct: 100, stall: 0, exp_blocks: 1, exp_last_strb: 8'h0F};
        vecs[4] = '{n: 9,  pct: 40,  stall: 2, exp_blocks: 5, exp_last_strb: 8'h0F};
        vecs[5] = '{n: 12, pct: 70,  stall: 0, exp_blocks: 6, exp_last_strb: 8'hFF};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < 16; i++) words[i] = $urandom();
            if (v == 0) begin
                words[0] = 32'h11111111; words[1] = 32'h22222222;
                words[2] = 32'h33333333; words[3] = 32'h44444444;
            end
            run_msg(vecs[v].n, vecs[v].pct, vecs[v].stall, nobs, lstrb);
            chk("tbl_nblk", nobs, vecs[v].exp_blocks);
            chk("tbl_last_strb", lstrb, vecs[v].exp_last_strb);
            finish_digest(rand_digest());
        end

        // rom_vld_i while waiting for the digest
        do_reset();
        for (int i = 0; i < 16; i++) words[i] = $urandom();
        run_msg(2, 100, 0, nobs, lstrb);
        rom_vld_i = 1'b1; rom_data_i = 32'hDEADBEEF;
        @(posedge clk_i); #1;
        chk("vld_wait_err", kmac_err_o, 1);
        chk("vld_wait_done", kmac_done_o, 1);
        chk("vld_wait_digest", kmac_digest_o, 0);
        chk("vld_wait_rdy", rom_rdy_o, 0);
        rom_vld_i = 1'b0;
        @(posedge clk_i); #1;
        chk("vld_wait_done_once", kmac_done_o, 0);
        chk("vld_wait_err_sticky", kmac_err_o, 1);
        chk("vld_wait_blk_vld", blk_vld_o, 0);
        core_done_i = 1'b1; core_digest_i = rand_digest();
        @(posedge clk_i); #1;
        core_done_i = 1'b0;
        chk("err_no_second_done", kmac_done_o, 0);
        chk("err_digest_zero", kmac_digest_o, 0);

        // core_done_i and core_err_i together
        do_reset();
        for (int i = 0; i < 16; i++) words[i] = $urandom();
        run_msg(2, 100, 0, nobs, lstrb);
        dg = rand_digest();
        core_done_i = 1'b1; core_err_i = 1'b1; core_digest_i = dg;
        @(posedge clk_i); #1;
        core_done_i = 1'b0; core_err_i = 1'b0;
        chk("both_err", kmac_err_o, 1);
        chk("both_done", kmac_done_o, 1);
        chk("both_digest", kmac_digest_o, 0);
        @(posedge clk_i); #1;
        chk("both_done_once", kmac_done_o, 0);

        // core_done_i while still absorbing
        do_reset();
        rom_vld_i = 1'b1; rom_data_i = $urandom();
        @(posedge clk_i); #1;
        rom_vld_i = 1'b0;
        core_done_i = 1'b1; core_digest_i = rand_digest();
        @(posedge clk_i); #1;
        core_done_i = 1'b0;
        chk("early_done_err", kmac_err_o, 1);
        chk("early_done_pulse", kmac_done_o, 1);
        chk("early_done_digest", kmac_digest_o, 0);
        chk("early_done_blk_vld", blk_vld_o, 0);

        // reset mid-message, then a clean 2-word message
        do_reset();
        blk_rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rom_vld_i = 1'b1; rom_data_i = $urandom();
            @(posedge clk_i); #1;
        end
        do_reset();
        for (int i = 0; i < 16; i++) words[i] = $urandom();
        run_msg(2, 100, 0, nobs, lstrb);
        chk("rst_mid_nblk", nobs, 1);
        chk("rst_mid_strb", lstrb, 8'hFF);
        finish_digest(rand_digest());

        // random messages
        for (int r = 0; r < 20; r++) begin
            int n;
            do_reset();
            n = $urandom_range(12, 1);
            for (int i = 0; i < 16; i++) words[i] = $urandom();
            run_msg(n, $urandom_range(100, 20), $urandom_range(3, 0), nobs, lstrb);
            chk("rnd_nblk", nobs, (n + 1) / 2);
            chk("rnd_last_strb", lstrb, (n % 2 == 1) ? 8'h0F : 8'hFF);
            finish_digest(rand_digest());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
